// File: rtl/data_mem_wait.sv
// ---------------------------------------------------------------------------
// data_mem_wait
// Data memory for the MEM stage with a configurable number of wait cycles.
// Supports byte / halfword / word accesses (little-endian), sign or zero
// extension on loads, and reports misaligned or illegal-size requests with
// err instead of touching memory. stall freezes the pipeline while a request
// is outstanding; done pulses for one cycle when the result is available.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   MemRd     load request
//   MemWr     store request (wins over MemRd)
//   size      00 byte, 01 halfword, 10 word, 11 illegal
//   sign_ext  loads: 1 sign-extend, 0 zero-extend
//   Address   byte address; word index = Address[ADDR_W+1:2], upper bits wrap
//   Data_in   right-justified store data
//   Data_out  registered load result
//   stall     request outstanding; inputs must be held while high
//   done      one-cycle completion pulse
//   err       qualifies done: request was misaligned or illegal
// ---------------------------------------------------------------------------
module data_mem_wait #(
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] Address,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WAIT     = 2'd1;
  localparam logic [1:0] DONE     = 2'd2;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);
  localparam logic       NO_WAIT  = (LATENCY == 0);

  // Byte-lane write mask; halfword and word lanes are aligned, so the lane
  // offset times 8 is also the correct shift for them.
  function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] lane);
    logic [31:0] m;
    case (sz)
      2'b00:   m = 32'h0000_00FF << {lane, 3'b000};
      2'b01:   m = 32'h0000_FFFF << {lane, 3'b000};
      2'b10:   m = 32'hFFFF_FFFF;
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  // Extract the addressed byte/half from a word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic sx);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (sz)
      2'b00:   r = sx ? {{24{sh[7]}}, sh[7:0]} : {24'h00_0000, sh[7:0]};
      2'b01:   r = sx ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      2'b10:   r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  logic [31:0]       mem_r [DEPTH] = '{default: 32'h0000_0000};
  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [3:0]        cnt_r;
  logic [31:0]       data_out_r;
  logic              err_r;
  logic              op_wr_r;
  logic [1:0]        op_size_r;
  logic              op_sx_r;
  logic [1:0]        op_lane_r;
  logic [ADDR_W-1:0] op_idx_r;
  logic [31:0]       op_data_r;

  logic              req_s;
  logic              bad_s;
  logic              commit_s;
  logic              acc_wr_s;
  logic [1:0]        acc_size_s;
  logic              acc_sx_s;
  logic [1:0]        acc_lane_s;
  logic [ADDR_W-1:0] acc_idx_s;
  logic [31:0]       acc_data_s;
  logic [31:0]       rd_word_s;
  logic [31:0]       mask_s;
  logic              unused_s;

  assign req_s    = MemRd | MemWr;
  assign bad_s    = (size == 2'b11) | ((size == 2'b01) & Address[0]) |
                    ((size == 2'b10) & (Address[1:0] != 2'b00));
  assign unused_s = ^Address[31:ADDR_W+2];

  // Access fields: live inputs for a zero-wait access from IDLE, latched copy otherwise.
  always_comb begin
    if (state_r == IDLE) begin
      acc_wr_s   = MemWr;
      acc_size_s = size;
      acc_sx_s   = sign_ext;
      acc_lane_s = Address[1:0];
      acc_idx_s  = Address[ADDR_W+1:2];
      acc_data_s = Data_in;
    end else begin
      acc_wr_s   = op_wr_r;
      acc_size_s = op_size_r;
      acc_sx_s   = op_sx_r;
      acc_lane_s = op_lane_r;
      acc_idx_s  = op_idx_r;
      acc_data_s = op_data_r;
    end
  end

  // A reset on the commit edge discards the access.
  assign commit_s  = ~reset & (((state_r == IDLE) & req_s & ~bad_s & NO_WAIT) |
                               ((state_r == WAIT) & (cnt_r == 4'd0)));
  assign rd_word_s = mem_r[acc_idx_s];
  assign mask_s    = lane_mask(acc_size_s, acc_lane_s);

  // Next-state logic for IDLE -> (WAIT) -> DONE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          if (bad_s || NO_WAIT) begin
            state_nxt_s = DONE;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Memory array: read-modify-write of the addressed lanes; never cleared by reset.
  always_ff @(posedge clk) begin
    if (commit_s && acc_wr_s) begin
      mem_r[acc_idx_s] <= (rd_word_s & ~mask_s) | ((acc_data_s << {acc_lane_s, 3'b000}) & mask_s);
    end
  end

  // Control state, request latch, wait counter, err flag and load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      data_out_r <= 32'h0000_0000;
      err_r      <= 1'b0;
      op_wr_r    <= 1'b0;
      op_size_r  <= 2'b00;
      op_sx_r    <= 1'b0;
      op_lane_r  <= 2'b00;
      op_idx_r   <= '0;
      op_data_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        IDLE: begin
          if (req_s && bad_s) begin
            err_r      <= 1'b1;
            data_out_r <= 32'h0000_0000;
          end else if (req_s) begin
            err_r     <= 1'b0;
            cnt_r     <= CNT_INIT;
            op_wr_r   <= MemWr;
            op_size_r <= size;
            op_sx_r   <= sign_ext;
            op_lane_r <= Address[1:0];
            op_idx_r  <= Address[ADDR_W+1:2];
            op_data_r <= Data_in;
          end else begin
            err_r <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end else begin
            cnt_r <= cnt_r;
          end
        end
        DONE:    err_r <= 1'b0;
        default: err_r <= 1'b0;
      endcase
      if (commit_s && !acc_wr_s) begin
        data_out_r <= load_extract(rd_word_s, acc_size_s, acc_lane_s, acc_sx_s);
      end
    end
  end

  assign stall    = ((state_r == IDLE) & req_s) | (state_r == WAIT);
  assign done     = (state_r == DONE);
  assign err      = err_r;
  assign Data_out = data_out_r;

endmodule

// File: tb/tb_data_mem_wait.sv
module tb_data_mem_wait;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_rd, a_wr, a_sx, a_stall, a_done, a_err;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_din, a_out;
  logic        b_rd, b_wr, b_sx, b_stall, b_done, b_err;
  logic [1:0]  b_size;
  logic [31:0] b_addr, b_din, b_out;

  data_mem_wait #(.ADDR_W(6), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .MemRd(a_rd), .MemWr(a_wr), .size(a_size),
    .sign_ext(a_sx), .Address(a_addr), .Data_in(a_din), .Data_out(a_out),
    .stall(a_stall), .done(a_done), .err(a_err));

  data_mem_wait #(.ADDR_W(6), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .MemRd(b_rd), .MemWr(b_wr), .size(b_size),
    .sign_ext(b_sx), .Address(b_addr), .Data_in(b_din), .Data_out(b_out),
    .stall(b_stall), .done(b_done), .err(b_err));

  bit          use_b;
  logic        m_stall, m_done, m_err;
  logic [31:0] m_out;
  assign m_stall = use_b ? b_stall : a_stall;
  assign m_done  = use_b ? b_done  : a_done;
  assign m_err   = use_b ? b_err   : a_err;
  assign m_out   = use_b ? b_out   : a_out;

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed memory image per instance plus last Data_out.
  logic [7:0]  model_mem [2][256];
  logic [31:0] last_out  [2];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  sz;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] din;
    logic        e_err;
    logic [31:0] e_out;
  } vec_t;

  vec_t tab[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_apply(input bit sel, input logic rd, input logic wr,
                                      input logic [1:0] sz, input logic sx,
                                      input logic [31:0] addr, input logic [31:0] din,
                                      output logic e_err, output logic [31:0] e_out);
    int n;
    int a;
    logic [31:0] v;
    logic bad;
    bad = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
    if (bad) begin
      e_err = 1'b1;
      e_out = 32'h0;
    end else begin
      e_err = 1'b0;
      n = 1 << sz;
      a = int'(addr[7:0]);
      if (wr) begin
        for (int i = 0; i < n; i++) model_mem[sel][a + i] = din[8*i +: 8];
        e_out = last_out[sel];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(model_mem[sel][a + i]) << (8 * i));
        if (rd && sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        e_out = v;
      end
    end
    last_out[sel] = e_out;
  endfunction

  task automatic apply(input bit sel, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] addr, input logic [31:0] din,
                       input logic exp_err, input logic [31:0] exp_out, input string name);
    int n;
    int exp_st;
    @(negedge clk);
    use_b = sel;
    if (sel) begin
      b_rd = rd; b_wr = wr; b_size = sz; b_sx = sx; b_addr = addr; b_din = din;
    end else begin
      a_rd = rd; a_wr = wr; a_size = sz; a_sx = sx; a_addr = addr; a_din = din;
    end
    #1;
    n = 0;
    while (m_stall && n < 40) begin
      n++;
      @(negedge clk);
    end
    exp_st = exp_err ? 1 : (sel ? 1 : 3);
    chk({name, " stall_cycles"}, 32'(n), 32'(exp_st));
    chk({name, " done"}, {31'h0, m_done}, 32'h1);
    chk({name, " err"}, {31'h0, m_err}, {31'h0, exp_err});
    chk({name, " Data_out"}, m_out, exp_out);
    a_rd = 1'b0; a_wr = 1'b0; b_rd = 1'b0; b_wr = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic        e_err;
    logic [31:0] e_out;
    int          pulses;
    int          r;
    logic [1:0]  sz;
    logic [31:0] ad;
    bit          sel;

    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 256; k++) model_mem[s][k] = 8'h00;
      last_out[s] = 32'h0;
    end

    //            rd    wr    sz     sx    addr          din           err   out
    tab[0]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tab[1]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tab[2]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344, 1'b0, 32'hDEAD_BEEF};
    tab[3]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_000B, 32'h1234_56A5, 1'b0, 32'hDEAD_BEEF};
    tab[4]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'hA522_3344};
    tab[5]  = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0,         1'b0, 32'hFFFF_FFA5};
    tab[6]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0,         1'b0, 32'h0000_00A5};
    tab[7]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h8001_0000, 1'b0, 32'h0000_00A5};
    tab[8]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0,         1'b0, 32'hFFFF_8001};
    tab[9]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 1'b0, 32'hFFFF_8001};
    tab[10] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_BEEF, 1'b1, 32'h0000_0000};
    tab[11] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'hCAFE_F00D};
    tab[12] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0,         1'b1, 32'h0000_0000};
    tab[13] = '{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_0000};
    tab[14] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'h0BAD_C0DE, 1'b0, 32'h0000_0000};
    tab[15] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0BAD_C0DE};
    tab[16] = '{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_000C, 32'h55AA_55AA, 1'b0, 32'h0BAD_C0DE};
    tab[17] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 32'h55AA_55AA};
    tab[18] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_000A, 32'h0,         1'b0, 32'h0000_8001};
    tab[19] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0,         1'b0, 32'hFFFF_FF80};
    tab[20] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_000A, 32'h0,         1'b0, 32'h0000_0001};
    tab[21] = '{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0008, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    tab[22] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h8001_0000};

    use_b = 1'b0;
    reset = 1'b1;
    a_rd = 1'b0; a_wr = 1'b0; a_size = 2'b00; a_sx = 1'b0; a_addr = 32'h0; a_din = 32'h0;
    b_rd = 1'b0; b_wr = 1'b0; b_size = 2'b00; b_sx = 1'b0; b_addr = 32'h0; b_din = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset Data_out", a_out, 32'h0);
    chk("reset done", {31'h0, a_done}, 32'h0);
    chk("reset err", {31'h0, a_err}, 32'h0);
    chk("reset stall idle", {31'h0, a_stall}, 32'h0);
    a_rd = 1'b1;
    #1;
    chk("reset stall with req", {31'h0, a_stall}, 32'h1);
    a_rd = 1'b0;
    reset = 1'b0;

    // Directed table on the LATENCY=2 instance.
    for (int i = 0; i < 23; i++) begin
      model_apply(1'b0, tab[i].rd, tab[i].wr, tab[i].sz, tab[i].sx, tab[i].addr, tab[i].din,
                  e_err, e_out);
      apply(1'b0, tab[i].rd, tab[i].wr, tab[i].sz, tab[i].sx, tab[i].addr, tab[i].din,
            tab[i].e_err, tab[i].e_out, $sformatf("tab%0d", i));
    end

    // LATENCY=0 instance: one-cycle stall per access.
    model_apply(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0F0F_0F0F, e_err, e_out);
    apply(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0F0F_0F0F, 1'b0, 32'h0, "lat0_store");
    model_apply(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, e_err, e_out);
    apply(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b0, 32'h0000_0F0F, "lat0_loadh");
    model_apply(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, e_err, e_out);
    apply(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h21, 32'h0, 1'b1, 32'h0, "lat0_misaligned");

    // Reset in the second WAIT cycle of a store: the store must be dropped.
    model_apply(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, e_err, e_out);
    apply(1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 1'b0, 32'h8001_0000, "st10");
    @(negedge clk);
    use_b = 1'b0;
    a_wr = 1'b1; a_size = 2'b10; a_addr = 32'h10; a_din = 32'h7777_7777;
    #1;
    chk("midrst stall c", {31'h0, a_stall}, 32'h1);
    @(negedge clk);
    chk("midrst stall wait1", {31'h0, a_stall}, 32'h1);
    @(negedge clk);
    chk("midrst stall wait2", {31'h0, a_stall}, 32'h1);
    reset = 1'b1;
    a_wr = 1'b0;
    @(negedge clk);
    chk("midrst Data_out", a_out, 32'h0);
    chk("midrst done", {31'h0, a_done}, 32'h0);
    chk("midrst err", {31'h0, a_err}, 32'h0);
    chk("midrst stall", {31'h0, a_stall}, 32'h0);
    reset = 1'b0;
    last_out[0] = 32'h0;
    last_out[1] = 32'h0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_done) pulses++;
    end
    chk("midrst no done", 32'(pulses), 32'h0);
    model_apply(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e_err, e_out);
    apply(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'h1234_5678, "midrst reload");

    // Randomized accesses on both instances against the reference model.
    for (int i = 0; i < 200; i++) begin
      sel = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 2);
      sz  = ($urandom_range(0, 9) > 8) ? 2'b11 : 2'($urandom_range(0, 2));
      ad  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) ad[0] = 1'b0;
        if (sz == 2'b10) ad[1:0] = 2'b00;
      end
      a_sx = 1'($urandom_range(0, 1));
      model_apply(sel, (r != 1), (r != 0), sz, a_sx, ad, ad ^ 32'h5A5A_A5A5, e_err, e_out);
      apply(sel, (r != 1), (r != 0), sz, a_sx, ad, ad ^ 32'h5A5A_A5A5, e_err, e_out,
            $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_wait.md
# data_mem_wait

Parametrised successor to the single-cycle data memory in the MEM stage. It supports configurable access latency and byte, halfword and word accesses, with sign or zero extension on loads. It raises a stall to freeze the pipeline while an access is outstanding. Misaligned or illegal-size requests are detected and reported instead of corrupting memory.

## Interface
- ADDR_W, 6, word-index bits; depth = 2**ADDR_W words of 32 bits.
- LATENCY, 2, extra wait cycles per access; legal range 0..15.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- MemRd  in  1  load request.
- MemWr  in  1  store request; wins if MemRd also high.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 sign-extends, 0 zero-extends.
- Address  in  32  byte address; word index = Address[ADDR_W+1:2]; higher bits ignored, so accesses wrap.
- Data_in  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- Data_out  out  32  registered load result.
- stall  out  1  hold the pipeline; request inputs must stay stable while high.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done when the request was misaligned or size=11.

## Operation
- Memory is little-endian: byte lane k = bits [8k+7:8k] of a word, selected by Address[1:0].
- Memory initialises to zero at time 0. reset does not clear it.
- req = MemRd | MemWr.
- bad = (size==11) | (size==01 & Address[0]) | (size==10 & Address[1:0]!=0).
- FSM states: IDLE, WAIT, DONE.
  - IDLE, no req: stay in IDLE.
  - IDLE, req & bad: go to DONE with err=1. No memory access. Data_out <= 0.
  - IDLE, req & !bad: latch op, lane, size, sign_ext, index and data.
    - LATENCY=0: perform the access at this edge, go to DONE.
    - Otherwise: cnt <= LATENCY-1, go to WAIT.
  - WAIT: if cnt!=0, decrement cnt. If cnt==0, perform the access at this edge and go to DONE.
  - DONE: go to IDLE unconditionally. A request still present in DONE is the old one and is never relaunched.
- Perform, store: write only the addressed lane(s). Other bytes are unchanged. Data_out holds its value.
- Perform, load: extract the addressed byte or half, extend per sign_ext, register into Data_out.
- stall = (state==IDLE & req) | (state==WAIT). Combinational from inputs in IDLE.
- done = (state==DONE). err is registered and valid only while done=1, otherwise 0.
- Request inputs changing while in WAIT are ignored, because all fields are latched.

## Timing
- Request first presented in cycle c, with state IDLE:
  - stall is high for cycles c..c+LATENCY (LATENCY+1 cycles).
  - Access commits at the edge ending cycle c+LATENCY.
  - Cycle c+LATENCY+1: DONE, stall=0, done=1, Data_out valid. The pipeline latches it at the end of this cycle.
- Error request: stall for 1 cycle (c), then done=err=1 in cycle c+1.
- Back-to-back: the next request is seen in IDLE at cycle c+LATENCY+2 at the earliest.
- Outputs after reset: state IDLE, Data_out=0, done=0, err=0, cnt=0. stall follows the IDLE equation, so it reads 1 if req is already asserted.
- Reset during WAIT: the pending store is discarded and memory is unchanged. A pending load returns nothing.
- Reset during DONE: done drops at the next edge.

## Test plan
- LATENCY=2, word store 0xDEADBEEF at 0x08, then word load 0x08:
  - Store: stall high 3 cycles, then done.
  - Load: Data_out=0xDEADBEEF in its done cycle.
- Byte store 0xA5 to 0x0B over 0x11223344, then loads from 0x08:
  - Word load: 0xA5223344.
  - Signed byte load from 0x0B: 0xFFFFFFA5. Unsigned: 0x000000A5.
- Halfword load 0x0A with sign_ext=1 on word 0x80010000 -> 0xFFFF8001.
- Misaligned and illegal requests:
  - Halfword store at 0x05, or word load at 0x06: 1 stall cycle, then done=err=1, memory unchanged, Data_out=0.
  - size=11: same response.
- Wrap and precedence, ADDR_W=6:
  - Store at 0x104 aliases to 0x04.
  - MemRd=MemWr=1: treated as a store, Data_out unchanged.
- Reset mid-operation: assert reset in the second WAIT cycle of a store to 0x10 -> memory[4] unchanged, done never pulses, all outputs at reset values.
- LATENCY=0: each access stalls exactly 1 cycle.
